// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared types and constants for the instruction-fetch stage.
//               Defines the instruction and address bus widths, the reset and
//               NOP constants, and the {addr, inst} entry held in the fetch
//               buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    // Bus widths (InstAddrBus / InstBus)
    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;

    // Reset-level and idle constants
    localparam inst_addr_t ZERO_INST_ADDR = 32'h0000_0000;
    localparam inst_t      NOP_INST       = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic       RST_ENABLE     = 1'b0;           // reset is active-low

    // One fetch-buffer entry: the PC and the instruction fetched from it
    typedef struct packed {
        inst_addr_t addr;
        inst_t      inst;
    } fetch_entry_t;

    // Redirect targets are forced to a word boundary
    function automatic inst_addr_t word_align(input inst_addr_t a);
        return a & ~32'h0000_0003;
    endfunction

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous DEPTH-entry FIFO of {addr, inst} fetch entries.
//               Head entry is read combinationally from storage. Push and pop
//               may happen together at any fill level; flush empties the FIFO
//               and takes priority over push/pop.
// Ports       : clk_i, rst_i (async, active-low)
//               push_i/data_i   - write an entry at the tail
//               pop_i           - retire the head entry
//               flush_i         - discard all entries
//               data_o          - head entry
//               count_o/empty_o/full_o - fill status
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  fetch_entry_t     data_i,
    output fetch_entry_t     data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        // A full FIFO only accepts a push when the head leaves the same cycle
        w_push   = push_i && (!full_o || pop_i);
        w_pop    = pop_i && !empty_o;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (w_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (rst_i == RST_ENABLE) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{addr: ZERO_INST_ADDR, inst: NOP_INST};
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (w_push && !flush_i) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Owns the PC, issues word-aligned
//               requests over a req/gnt/rvalid handshake, buffers returned
//               {pc, inst} pairs in fetch_fifo and presents them to decode
//               with valid/ready. Branch (EX) and jump (ID) redirects flush
//               the buffer and squash responses still in flight.
// Ports       : clk_i, rst_i (async, active-low)
//               imem_req_o/imem_addr_o/imem_gnt_i   - request channel
//               imem_rvalid_i/imem_rdata_i          - in-order response channel
//               inst_valid_o/inst_ready_i/inst_addr_o/inst_o - decode channel
//               jump_enable_i/jump_addr_i           - decode redirect
//               branch_taken_i/branch_addr_i        - execute redirect
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter inst_addr_t RESET_PC   = 32'h0000_0000,
    parameter int         FIFO_DEPTH = 2,
    parameter int         CNT_W      = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_addr_o,
    output logic [31:0] inst_o,
    input  logic        jump_enable_i,
    input  logic [31:0] jump_addr_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_addr_i
);

    // Outstanding requests plus buffered entries may never exceed this
    localparam logic [CNT_W:0] ISSUE_BOUND = (CNT_W + 1)'(FIFO_DEPTH);

    inst_addr_t       pc_q, pc_d;
    inst_addr_t       resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] discard_q, discard_d;

    logic             w_redirect;
    inst_addr_t       w_target;
    logic [CNT_W:0]   w_inflight;
    logic             w_grant;
    logic             w_rsp;
    logic             w_drop;
    logic             w_push;
    logic             w_pop;
    fetch_entry_t     w_push_data;
    fetch_entry_t     w_head;
    logic [CNT_W-1:0] w_fifo_count;
    logic             w_fifo_empty;
    logic             w_fifo_full;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fetch_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .flush_i (w_redirect),
        .data_i  (w_push_data),
        .data_o  (w_head),
        .count_o (w_fifo_count),
        .empty_o (w_fifo_empty),
        .full_o  (w_fifo_full)
    );

    always_comb begin
        // The branch is the older instruction, so it wins over a jump
        w_redirect = branch_taken_i | jump_enable_i;
        w_target   = word_align(branch_taken_i ? branch_addr_i : jump_addr_i);

        w_inflight = {1'b0, outst_q} + {1'b0, w_fifo_count};
        imem_req_o = (rst_i != RST_ENABLE) && !w_redirect && (w_inflight < ISSUE_BOUND);
        imem_addr_o = pc_q;
        w_grant    = imem_req_o && imem_gnt_i;

        // A response with nothing outstanding is illegal and ignored
        w_rsp  = imem_rvalid_i && (outst_q != '0);
        w_drop = w_rsp && (discard_q != '0);
        w_push = w_rsp && !w_drop && !w_redirect;
        w_push_data = '{addr: resp_pc_q, inst: imem_rdata_i};

        inst_valid_o = !w_fifo_empty;
        inst_addr_o  = w_head.addr;
        inst_o       = w_head.inst;
        // The flush replaces any pop on a redirect cycle
        w_pop = inst_valid_o && inst_ready_i && !w_redirect;
    end

    always_comb begin
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        discard_d = discard_q;
        outst_d   = outst_q + CNT_W'(w_grant) - CNT_W'(w_rsp);
        if (w_redirect) begin
            pc_d      = w_target;
            resp_pc_d = w_target;
            // Everything still in flight after this cycle belongs to the old path
            discard_d = outst_q - CNT_W'(w_rsp);
        end else begin
            if (w_grant) pc_d      = pc_q + 32'd4;
            if (w_push)  resp_pc_d = resp_pc_q + 32'd4;
            if (w_drop)  discard_d = discard_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (rst_i == RST_ENABLE) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            outst_q   <= '0;
            discard_q <= '0;
        end else begin
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
        end
    end

    rvalid_legal_a : assert property (@(posedge clk_i) disable iff (rst_i == RST_ENABLE)
        !(imem_rvalid_i && (outst_q == '0)));

    push_fits_a : assert property (@(posedge clk_i) disable iff (rst_i == RST_ENABLE)
        !(w_push && w_fifo_full && !w_pop));

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A queue-based reference
//               model tracks requests in flight (live or squashed), the
//               buffered instructions and the next fetch address; random and
//               directed traffic is compared against it every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_o;
    logic        jump_enable_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_addr_i = '0;

    fetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (2)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_gnt_i     (imem_gnt_i),
        .imem_rvalid_i  (imem_rvalid_i),
        .imem_rdata_i   (imem_rdata_i),
        .inst_valid_o   (inst_valid_o),
        .inst_ready_i   (inst_ready_i),
        .inst_addr_o    (inst_addr_o),
        .inst_o         (inst_o),
        .jump_enable_i  (jump_enable_i),
        .jump_addr_i    (jump_addr_i),
        .branch_taken_i (branch_taken_i),
        .branch_addr_i  (branch_addr_i)
    );

    always #5 clk_i = ~clk_i;

    // Reference model state
    typedef struct {
        logic [31:0] addr;
        bit          live;
    } req_t;

    req_t        inflight[$];
    logic [31:0] buf_q[$];
    logic [31:0] exp_pc;

    int n_checks = 0;
    int n_errs   = 0;

    // Traffic knobs (percent) and directed redirect controls
    int          p_gnt = 100, p_rv = 100, p_rdy = 100, p_redir = 0;
    bit          br_en = 0, jp_en = 0;
    logic [31:0] br_addr = '0, jp_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        inflight.delete();
        buf_q.delete();
        exp_pc = RST_PC;
    endtask

    task automatic check_reset_outputs(input string when);
        chk({when, "_req"},   {31'd0, imem_req_o},   32'd0);
        chk({when, "_addr"},  imem_addr_o,           RST_PC);
        chk({when, "_valid"}, {31'd0, inst_valid_o}, 32'd0);
        chk({when, "_ipc"},   inst_addr_o,           32'd0);
        chk({when, "_inst"},  inst_o,                32'h0000_0013);
    endtask

    // One clock: drive at negedge, check combinational outputs, then advance
    // the model at the posedge with the same inputs.
    task automatic cycle();
        bit          b, j, redir, rsp, pop, exp_req, grant;
        logic [31:0] ba, ja, tgt;
        req_t        r;
        @(negedge clk_i);
        if (p_redir > 0) begin
            b  = ($urandom_range(99) < p_redir);
            j  = ($urandom_range(99) < p_redir);
            ba = $urandom;
            ja = $urandom;
        end else begin
            b = br_en; j = jp_en; ba = br_addr; ja = jp_addr;
        end
        branch_taken_i = b;
        branch_addr_i  = ba;
        jump_enable_i  = j;
        jump_addr_i    = ja;
        imem_gnt_i     = ($urandom_range(99) < p_gnt);
        rsp            = (inflight.size() > 0) && ($urandom_range(99) < p_rv);
        imem_rvalid_i  = rsp;
        imem_rdata_i   = rsp ? mem_word(inflight[0].addr) : $urandom;
        inst_ready_i   = ($urandom_range(99) < p_rdy);
        #1;
        redir   = b || j;
        tgt     = (b ? ba : ja) & 32'hFFFF_FFFC;
        exp_req = !redir && ((inflight.size() + buf_q.size()) < DEPTH);
        chk("req",   {31'd0, imem_req_o},   {31'd0, exp_req});
        chk("addr",  imem_addr_o,           exp_pc);
        chk("valid", {31'd0, inst_valid_o}, {31'd0, (buf_q.size() > 0)});
        if (buf_q.size() > 0) begin
            chk("head_pc",   inst_addr_o, buf_q[0]);
            chk("head_inst", inst_o,      mem_word(buf_q[0]));
        end
        pop   = (buf_q.size() > 0) && inst_ready_i;
        grant = exp_req && imem_gnt_i;
        @(posedge clk_i);
        if (rsp) r = inflight.pop_front();
        if (redir) begin
            foreach (inflight[i]) inflight[i].live = 1'b0;
            buf_q.delete();
            exp_pc = tgt;
        end else begin
            if (pop) void'(buf_q.pop_front());
            if (rsp && r.live) buf_q.push_back(r.addr);
            if (grant) begin
                inflight.push_back('{addr: exp_pc, live: 1'b1});
                exp_pc = exp_pc + 32'd4;
            end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic redirect_cycle(input bit b, input logic [31:0] ba,
                                  input bit j, input logic [31:0] ja);
        br_en = b; br_addr = ba; jp_en = j; jp_addr = ja;
        cycle();
        br_en = 0; jp_en = 0;
    endtask

    // Let everything in flight return and be consumed
    task automatic drain();
        p_gnt = 0; p_rv = 100; p_rdy = 100;
        for (int k = 0; k < 20 && (inflight.size() + buf_q.size()) > 0; k++) cycle();
    endtask

    initial begin
        #1 rst_i = 1'b0;
        model_reset();
        #10;
        check_reset_outputs("rst0");
        @(negedge clk_i) rst_i = 1'b1;

        // Back-to-back streaming
        p_gnt = 100; p_rv = 100; p_rdy = 100;
        run(20);

        // Decode stall for 6 cycles, then release
        p_rdy = 0;
        run(6);
        p_rdy = 100;
        run(10);

        // Two outstanding requests squashed by a jump
        drain();
        p_gnt = 100; p_rv = 0;
        run(2);
        redirect_cycle(1'b0, 32'h0, 1'b1, 32'h0000_0100);
        p_rv = 100;
        run(8);

        // Branch and jump together: branch wins
        redirect_cycle(1'b1, 32'h0000_0040, 1'b1, 32'h0000_0080);
        run(8);

        // Misaligned jump target
        redirect_cycle(1'b0, 32'h0, 1'b1, 32'h0000_0103);
        run(6);

        // PC wrap at the top of the address space
        redirect_cycle(1'b1, 32'hFFFF_FFF4, 1'b0, 32'h0);
        run(8);

        // Randomized traffic with random redirects
        p_redir = 4;
        for (int blk = 0; blk < 15; blk++) begin
            p_gnt = $urandom_range(20, 100);
            p_rv  = $urandom_range(20, 100);
            p_rdy = $urandom_range(20, 100);
            run(100);
        end
        p_redir = 0;

        // Asynchronous reset with one request outstanding
        drain();
        p_gnt = 100; p_rv = 0; p_rdy = 100;
        cycle();
        #2;
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b0;
        rst_i = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        p_gnt = 100; p_rv = 100; p_rdy = 100;
        run(12);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule : tb_fetch_unit
`default_nettype wire
